// File: rtl/minterm_479_detector_if.sv
// Sample/result bundle for the f = sum m(4,7,9) detector: BCD nibble in, decode results out.
interface minterm_479_detector_if #(
  parameter int unsigned CNT_W = 8
);
  logic             en;
  logic             a;
  logic             b;
  logic             c;
  logic             d;
  logic             out;
  logic [9:0]       dec_n;
  logic             invalid;
  logic [CNT_W-1:0] hit_cnt;

  modport master (
    output en, a, b, c, d,
    input  out, dec_n, invalid, hit_cnt
  );

  modport slave (
    input  en, a, b, c, d,
    output out, dec_n, invalid, hit_cnt
  );
endinterface

// File: rtl/minterm_479_detector.sv
// Registered 4/7/9 detector with 7442-style active-low one-of-ten decode,
// invalid-code flag and saturating hit counter.
module minterm_479_detector #(
  parameter int unsigned CNT_W = 8
) (
  input logic                  clk,
  input logic                  rst,
  minterm_479_detector_if.slave bus
);

  localparam int unsigned CODE_W = 4;
  localparam int unsigned DEC_W  = 10;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CODE_W-1:0] v_c;
  logic              f_c;
  logic [DEC_W-1:0]  dec_n_c;
  logic              invalid_c;

  logic              out_q;
  logic [DEC_W-1:0]  dec_n_q;
  logic              invalid_q;
  logic [CNT_W-1:0]  hit_cnt_q;

  // Next-sample decode of the incoming nibble
  always_comb begin
    v_c       = {bus.a, bus.b, bus.c, bus.d};
    f_c       = 1'b0;
    dec_n_c   = '1;
    invalid_c = (v_c >= CODE_W'(10));
    case (v_c)
      CODE_W'(4), CODE_W'(7), CODE_W'(9): f_c = 1'b1;
      default:                            f_c = 1'b0;
    endcase
    for (int unsigned k = 0; k < DEC_W; k++) begin
      if (v_c == CODE_W'(k)) dec_n_c[k] = 1'b0;
    end
  end

  // Output registers; reset wins over enable, counter sticks at its maximum
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q     <= 1'b0;
      dec_n_q   <= '1;
      invalid_q <= 1'b0;
      hit_cnt_q <= '0;
    end else if (bus.en) begin
      out_q     <= f_c;
      dec_n_q   <= dec_n_c;
      invalid_q <= invalid_c;
      if (f_c && (hit_cnt_q != CNT_MAX)) begin
        hit_cnt_q <= hit_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.out     = out_q;
  assign bus.dec_n   = dec_n_q;
  assign bus.invalid = invalid_q;
  assign bus.hit_cnt = hit_cnt_q;

endmodule

// File: tb/tb_minterm_479_detector.sv
// Directed bench for minterm_479_detector: sweep, reset priority, enable hold,
// saturation, mid-run reset and counter-order stimulus.
module tb_minterm_479_detector;

  localparam int unsigned CNT_W = 8;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  minterm_479_detector_if #(.CNT_W(CNT_W)) bus ();

  minterm_479_detector #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v);
    {bus.a, bus.b, bus.c, bus.d} = v;
  endtask

  task automatic check_all(input string tag, input logic o, input logic [9:0] dn,
                           input logic inv, input logic [31:0] cnt);
    check({tag, ".out"},     32'(bus.out),     32'(o));
    check({tag, ".dec_n"},   32'(bus.dec_n),   32'(dn));
    check({tag, ".invalid"}, 32'(bus.invalid), 32'(inv));
    check({tag, ".hit_cnt"}, 32'(bus.hit_cnt), cnt);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Hand-written truth table for f = m(4,7,9), bit v is f(v)
  logic [15:0] f_tab;
  // Hand-written active-low decode per code; codes 10..15 decode to all ones
  logic [9:0]  dec_tab [16];

  initial begin
    int exp_cnt;
    logic [3:0] v;
    n_checks = 0;
    n_fail   = 0;
    f_tab = 16'b0000_0010_1001_0000;
    dec_tab[0]  = 10'h3FE; dec_tab[1]  = 10'h3FD; dec_tab[2]  = 10'h3FB;
    dec_tab[3]  = 10'h3F7; dec_tab[4]  = 10'h3EF; dec_tab[5]  = 10'h3DF;
    dec_tab[6]  = 10'h3BF; dec_tab[7]  = 10'h37F; dec_tab[8]  = 10'h2FF;
    dec_tab[9]  = 10'h1FF;
    for (int i = 10; i < 16; i++) dec_tab[i] = 10'h3FF;

    rst = 1'b0;
    bus.en = 1'b1;
    drive(4'd0);

    // Reset state
    do_reset();
    check_all("reset", 1'b0, 10'h3FF, 1'b0, 0);

    // Exhaustive sweep
    exp_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      drive(v);
      step();
      if (f_tab[i]) exp_cnt++;
      check_all($sformatf("sweep%0d", i), f_tab[i], dec_tab[i], (i >= 10), 32'(exp_cnt));
    end
    check("sweep_final_cnt", 32'(bus.hit_cnt), 32'd3);

    // Reset priority over enable with a hit code present
    rst = 1'b1;
    bus.en = 1'b1;
    drive(4'd4);
    step();
    rst = 1'b0;
    check_all("rst_prio", 1'b0, 10'h3FF, 1'b0, 0);

    // Enable hold
    drive(4'd7);
    step();
    check_all("hold_load", 1'b1, 10'h37F, 1'b0, 1);
    bus.en = 1'b0;
    drive(4'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      check_all($sformatf("hold%0d", i), 1'b1, 10'h37F, 1'b0, 1);
    end

    // Saturation
    bus.en = 1'b1;
    drive(4'd9);
    exp_cnt = 1;
    for (int i = 0; i < 300; i++) begin
      step();
      if (exp_cnt < 255) exp_cnt++;
      check($sformatf("sat_out%0d", i), 32'(bus.out), 32'd1);
      check($sformatf("sat_cnt%0d", i), 32'(bus.hit_cnt), 32'(exp_cnt));
    end
    check("sat_final", 32'(bus.hit_cnt), 32'd255);

    // Mid-run reset
    do_reset();
    drive(4'd4);
    for (int i = 0; i < 10; i++) step();
    check_all("mid_pre", 1'b1, 10'h3EF, 1'b0, 10);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_all("mid_rst", 1'b0, 10'h3FF, 1'b0, 0);
    step();
    check_all("mid_resume", 1'b1, 10'h3EF, 1'b0, 1);

    // Counter-order stimulus, two full periods
    do_reset();
    exp_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      v = 4'(i);
      drive(v);
      step();
      if ((v == 4'd4) || (v == 4'd7) || (v == 4'd9)) exp_cnt++;
      check($sformatf("cnt_out%0d", i), 32'(bus.out), 32'(f_tab[v]));
      check($sformatf("cnt_inv%0d", i), 32'(bus.invalid), 32'(v >= 4'd10));
    end
    check("cnt_hits", 32'(bus.hit_cnt), 32'd6);
    check("cnt_hits_model", 32'(bus.hit_cnt), 32'(exp_cnt));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
